pipe_stage_buf: RTL and testbench

- Parametrised successor to the fixed 32-bit stall/flush pipeline register pair. One elastic pipeline stage with a DATA_W-wide payload, per-entry valid bits and a valid/ready handshake on both sides.
- A 2-entry skid buffer (main + skid) decouples upstream from downstream back-pressure.
- Keeps the hard stall and flush controls used by the hazard unit.
- Adds an occupancy output and a saturating counter of flushed (squashed) entries for debug.
- Instantiated between any two CPU stages (IF/ID first, then ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_buf.sv | 85 ++++++++
 tb/tb_pipe_stage_buf.sv | 136 +++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic pipeline stage with a 2-entry skid buffer (main + skid).
// Stall freezes the stage; flush squashes held entries and counts them.
// All state updates on the falling edge of clk.
module pipe_stage_buf #(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] FLUSH_DATA = '0,
  parameter int                CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  squash_cnt
);

  logic              main_v, skid_v;
  logic [DATA_W-1:0] main_d, skid_d;
  logic              in_fire, out_fire;
  logic [CNT_W:0]    cnt_sum;

  // Handshake qualification; stall and flush block both sides.
  always_comb begin
    in_ready  = !skid_v && !stall && !flush;
    in_fire   = in_valid && in_ready;
    out_fire  = main_v && out_ready && !stall && !flush;
    occupancy = {1'b0, main_v} + {1'b0, skid_v};
    cnt_sum   = {1'b0, squash_cnt} + (CNT_W+1)'(main_v) + (CNT_W+1)'(skid_v);
  end

  assign out_valid = main_v;
  assign out_data  = main_d;

  // Entry state: flush squashes, stall holds, otherwise FIFO main/skid movement.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= FLUSH_DATA;
      skid_d <= FLUSH_DATA;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= FLUSH_DATA;
      skid_d <= FLUSH_DATA;
    end else if (!stall) begin
      if (skid_v) begin
        // Full: only drain; skid slides into main.
        if (out_fire) begin
          main_d <= skid_d;
          skid_v <= 1'b0;
        end
      end else if (main_v) begin
        if (out_fire && in_fire) begin
          main_d <= in_data;
        end else if (out_fire) begin
          main_v <= 1'b0;
        end else if (in_fire) begin
          skid_d <= in_data;
          skid_v <= 1'b1;
        end
      end else if (in_fire) begin
        main_d <= in_data;
        main_v <= 1'b1;
      end
    end
  end

  // Saturating count of valid entries discarded by flush.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      squash_cnt <= '0;
    end else if (flush) begin
      if (cnt_sum[CNT_W]) squash_cnt <= '1;
      else                squash_cnt <= cnt_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf (CNT_W=2 to reach saturation quickly).
module tb_pipe_stage_buf;
  localparam int          DW = 64;
  localparam int          CW = 2;
  localparam logic [DW-1:0] FD = 64'h0000_0000_0BAD_F00D;

  logic          clk = 1'b1;
  logic          rst, stall, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] squash_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_stage_buf #(.DATA_W(DW), .FLUSH_DATA(FD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy), .squash_cnt(squash_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next (active) falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic st(input string tag, input logic v, input logic [DW-1:0] d, input logic [1:0] occ);
    chk({tag, ".out_valid"}, DW'(out_valid), DW'(v));
    if (v) chk({tag, ".out_data"}, out_data, d);
    chk({tag, ".occ"}, DW'(occupancy), DW'(occ));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #3;
    chk("rst.out_valid", DW'(out_valid), 0);
    chk("rst.out_data",  out_data, FD);
    chk("rst.occ",       DW'(occupancy), 0);
    chk("rst.squash",    DW'(squash_cnt), 0);
    chk("rst.in_ready",  DW'(in_ready), 1);
    #3 rst = 1'b0;

    // Streaming at full throughput
    tick();
    in_valid = 1'b1; out_ready = 1'b1; in_data = 64'h1;
    tick(); st("s1", 1'b1, 64'h1, 2'd1);
    in_data = 64'h2;
    tick(); st("s2", 1'b1, 64'h2, 2'd1);
    in_data = 64'h3;
    tick(); st("s3", 1'b1, 64'h3, 2'd1);
    in_valid = 1'b0;
    tick(); st("s4", 1'b0, '0, 2'd0);

    // Back-pressure fills skid, then drains in order
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hA;
    tick(); st("bp1", 1'b1, 64'hA, 2'd1);
    in_data = 64'hB;
    #1 chk("bp1.in_ready", DW'(in_ready), 1);
    tick(); st("bp2", 1'b1, 64'hA, 2'd2);
    chk("bp2.in_ready", DW'(in_ready), 0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); st("bp3", 1'b1, 64'hB, 2'd1);
    tick(); st("bp4", 1'b0, '0, 2'd0);

    // Stall holds everything
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hC;
    tick(); st("stl0", 1'b1, 64'hC, 2'd1);
    stall = 1'b1; out_ready = 1'b1; in_data = 64'hD;
    #1 chk("stl.in_ready", DW'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      tick(); st("stl", 1'b1, 64'hC, 2'd1);
    end
    stall = 1'b0;
    #1 chk("stl.rel_in_ready", DW'(in_ready), 1);
    tick(); st("stl_pass", 1'b1, 64'hD, 2'd1);
    in_valid = 1'b0;
    tick(); st("stl_empty", 1'b0, '0, 2'd0);

    // Flush with stall, repeated to saturate the counter (2, 3, 3)
    for (int k = 0; k < 3; k++) begin
      out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hE0 + DW'(k);
      tick();
      in_data = 64'hF0 + DW'(k);
      tick(); st("fl.fill", 1'b1, 64'hE0 + DW'(k), 2'd2);
      in_valid = 1'b0; flush = 1'b1; stall = 1'b1; out_ready = 1'b1;
      #1 chk("fl.in_ready", DW'(in_ready), 0);
      tick();
      chk("fl.out_valid", DW'(out_valid), 0);
      chk("fl.out_data",  out_data, FD);
      chk("fl.occ",       DW'(occupancy), 0);
      chk("fl.squash",    DW'(squash_cnt), (k == 0) ? DW'(2) : DW'(3));
      flush = 1'b0; stall = 1'b0;
    end

    // Asynchronous reset mid-cycle while full
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h11;
    tick();
    in_data = 64'h22;
    tick(); st("ar.fill", 1'b1, 64'h11, 2'd2);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar.out_valid", DW'(out_valid), 0);
    chk("ar.out_data",  out_data, FD);
    chk("ar.occ",       DW'(occupancy), 0);
    chk("ar.squash",    DW'(squash_cnt), 0);
    #1 rst = 1'b0;
    in_valid = 1'b1; in_data = 64'h55;
    #1 chk("ar.in_ready", DW'(in_ready), 1);
    tick(); st("ar.first", 1'b1, 64'h55, 2'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); st("ar.drain", 1'b0, '0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
